// File: rtl/fpu_dispatch_if.sv
// Bundle of every non-clock/reset signal around fpu_dispatch.
//   upstream : in_valid/in_ready handshake carrying in_op, in_rs1, in_rs2, in_rd
//   unit     : fpu_operation, fpu_operand_1/2 out; fpu_result, fpu_ready back
//   writeback: wb_valid/wb_ready handshake carrying wb_data, wb_rd, wb_err
//   status   : busy
// master = the dispatch block, slave = its environment (requester, unit, writeback).
interface fpu_dispatch_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_rs1;
  logic [WIDTH-1:0] in_rs2;
  logic [4:0]       in_rd;

  logic [WIDTH-1:0] fpu_operand_1;
  logic [WIDTH-1:0] fpu_operand_2;
  logic [1:0]       fpu_operation;
  logic [WIDTH-1:0] fpu_result;
  logic             fpu_ready;

  logic             wb_valid;
  logic             wb_ready;
  logic [WIDTH-1:0] wb_data;
  logic [4:0]       wb_rd;
  logic             wb_err;

  logic             busy;

  modport master (
    input  in_valid, in_op, in_rs1, in_rs2, in_rd,
    input  fpu_result, fpu_ready,
    input  wb_ready,
    output in_ready,
    output fpu_operand_1, fpu_operand_2, fpu_operation,
    output wb_valid, wb_data, wb_rd, wb_err,
    output busy
  );

  modport slave (
    output in_valid, in_op, in_rs1, in_rs2, in_rd,
    output fpu_result, fpu_ready,
    output wb_ready,
    input  in_ready,
    input  fpu_operand_1, fpu_operand_2, fpu_operation,
    input  wb_valid, wb_data, wb_rd, wb_err,
    input  busy
  );
endinterface

// File: rtl/fpu_dispatch.sv
// Single-request dispatcher between an issue stage and a fixed-point unit.
// Accepts one request in IDLE, holds its operands on the unit through EXEC until
// fpu_ready (or a timeout), presents the result in RESP until writeback takes it,
// then spends one GAP cycle driving ADD/zero so the unit never sees two
// back-to-back multi-cycle ops.
// Ports:
//   clk   : clock, all state on rising edge
//   reset : asynchronous, active-high
//   bus   : fpu_dispatch_if.master (upstream, unit and writeback signals)
module fpu_dispatch #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 63
) (
  input logic            clk,
  input logic            reset,
  fpu_dispatch_if.master bus
);

  localparam logic [1:0] FpuAdd     = 2'd0;
  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp,
    StGap
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] rs1_q, rs1_d;
  logic [WIDTH-1:0] rs2_q, rs2_d;
  logic [4:0]       rd_q, rd_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] wb_data_q, wb_data_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic             wb_err_q, wb_err_d;

  // An unknown ready from the unit must never complete a request.
  logic fpu_ready_s;
  assign fpu_ready_s = (bus.fpu_ready === 1'b1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      op_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      wb_data_q <= '0;
      wb_rd_q   <= '0;
      wb_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      wb_data_q <= wb_data_d;
      wb_rd_q   <= wb_rd_d;
      wb_err_q  <= wb_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    wb_data_d = wb_data_q;
    wb_rd_d   = wb_rd_q;
    wb_err_d  = wb_err_q;

    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          op_d    = bus.in_op;
          rs1_d   = bus.in_rs1;
          rs2_d   = bus.in_rs2;
          rd_d    = bus.in_rd;
          cnt_d   = '0;
          state_d = StExec;
        end
      end
      StExec: begin
        cnt_d = cnt_q + 8'd1;
        // A result arriving on the timeout cycle still wins over the abort.
        if (fpu_ready_s) begin
          wb_data_d = bus.fpu_result;
          wb_rd_d   = rd_q;
          wb_err_d  = 1'b0;
          state_d   = StResp;
        end else if (cnt_q + 8'd1 == TimeoutCnt) begin
          wb_data_d = '0;
          wb_rd_d   = rd_q;
          wb_err_d  = 1'b1;
          state_d   = StResp;
        end
      end
      StResp: begin
        if (bus.wb_ready) begin
          state_d = StGap;
        end
      end
      StGap: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outside EXEC the unit sees ADD with zero operands so nothing long-running starts.
  always_comb begin
    bus.in_ready      = (state_q == StIdle);
    bus.busy          = (state_q != StIdle);
    bus.wb_valid      = (state_q == StResp);
    bus.wb_data       = wb_data_q;
    bus.wb_rd         = wb_rd_q;
    bus.wb_err        = wb_err_q;
    bus.fpu_operation = FpuAdd;
    bus.fpu_operand_1 = '0;
    bus.fpu_operand_2 = '0;
    if (state_q == StExec) begin
      bus.fpu_operation = op_q;
      bus.fpu_operand_1 = rs1_q;
      bus.fpu_operand_2 = rs2_q;
    end
  end

endmodule

// File: tb/tb_fpu_dispatch.sv
// Bench for fpu_dispatch: a behavioural fixed-point unit stub, a table of directed
// requests, hand-written reset and back-to-back sequences, and random requests
// checked against a request-level reference model.
module tb_fpu_dispatch;

  localparam int unsigned W  = 32;
  localparam int unsigned TO = 63;
  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_SUB  = 2'd1;
  localparam logic [1:0] OP_MUL  = 2'd2;
  localparam logic [1:0] OP_SQRT = 2'd3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fpu_dispatch_if #(.WIDTH(W)) bus ();

  fpu_dispatch #(
    .WIDTH  (W),
    .TIMEOUT(TO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int xfers    = 0;

  // Unit stub: ADD/SUB answer combinationally; MUL/SQRT raise ready in the
  // stub_delay-th consecutive cycle they are presented (0 = never).
  int stub_delay = 0;
  int stub_cnt   = 0;

  function automatic logic [31:0] mul_fx(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    return p[41:10];
  endfunction

  function automatic logic [31:0] sqrt_fx(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  always @(posedge clk) begin
    if (bus.fpu_operation == OP_MUL || bus.fpu_operation == OP_SQRT) stub_cnt <= stub_cnt + 1;
    else stub_cnt <= 0;
    if (bus.wb_valid && bus.wb_ready) xfers <= xfers + 1;
  end

  always_comb begin
    bus.fpu_ready  = 1'b0;
    bus.fpu_result = '0;
    case (bus.fpu_operation)
      OP_ADD: begin
        bus.fpu_ready  = 1'b1;
        bus.fpu_result = bus.fpu_operand_1 + bus.fpu_operand_2;
      end
      OP_SUB: begin
        bus.fpu_ready  = 1'b1;
        bus.fpu_result = bus.fpu_operand_1 - bus.fpu_operand_2;
      end
      OP_MUL: begin
        bus.fpu_ready  = (stub_delay != 0) && (stub_cnt >= stub_delay - 1);
        bus.fpu_result = mul_fx(bus.fpu_operand_1, bus.fpu_operand_2);
      end
      default: begin
        bus.fpu_ready  = (stub_delay != 0) && (stub_cnt >= stub_delay - 1);
        bus.fpu_result = sqrt_fx(bus.fpu_operand_1);
      end
    endcase
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Request-level model: what writeback must carry and how many edges after
  // acceptance wb_valid is first seen (EXEC cycles + 1).
  function automatic void ref_model(input logic [1:0] op, input logic [31:0] a,
                                    input logic [31:0] b, input int delay,
                                    output logic [31:0] data, output logic err,
                                    output int lat);
    int exec;
    if (op == OP_ADD || op == OP_SUB) begin
      data = (op == OP_ADD) ? a + b : a - b;
      err  = 1'b0;
      exec = 1;
    end else if (delay != 0 && delay <= int'(TO)) begin
      data = (op == OP_MUL) ? mul_fx(a, b) : sqrt_fx(a);
      err  = 1'b0;
      exec = delay;
    end else begin
      data = '0;
      err  = 1'b1;
      exec = int'(TO);
    end
    lat = exec + 1;
  endfunction

  // One full request: accept, EXEC hold, latency, RESP hold under backpressure,
  // GAP, back to IDLE, and exactly one writeback transfer.
  task automatic do_req(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input int delay,
                        input int stall, input logic [31:0] exp_data, input logic exp_err,
                        input int exp_lat);
    int k;
    int x0;
    x0 = xfers;
    @(negedge clk);
    stub_delay    = delay;
    bus.in_op     = op;
    bus.in_rs1    = a;
    bus.in_rs2    = b;
    bus.in_rd     = rd;
    bus.in_valid  = 1'b1;
    bus.wb_ready  = (stall == 0);
    k = 0;
    while (!bus.in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    check({name, " accept"}, 128'(bus.in_ready), 128'(1'b1));
    @(negedge clk);
    k = 1;
    while (!bus.wb_valid && k < 200) begin
      check({name, " exec_hold"},
            128'({bus.fpu_operation, bus.fpu_operand_1, bus.fpu_operand_2, bus.in_ready}),
            128'({op, a, b, 1'b0}));
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_op    = 2'($urandom_range(0, 3));
      bus.in_rs1   = $urandom;
      bus.in_rs2   = $urandom;
      bus.in_rd    = 5'($urandom_range(0, 31));
      @(negedge clk);
      k++;
    end
    check({name, " latency"}, 128'(k), 128'(exp_lat));
    for (int s = 0; s <= stall; s++) begin
      check({name, " resp_hold"},
            128'({bus.wb_valid, bus.wb_data, bus.wb_rd, bus.wb_err, bus.in_ready, bus.busy}),
            128'({1'b1, exp_data, rd, exp_err, 1'b0, 1'b1}));
      if (s == stall) bus.wb_ready = 1'b1;
      else bus.in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    check({name, " gap"},
          128'({bus.wb_valid, bus.in_ready, bus.busy, bus.fpu_operation,
                bus.fpu_operand_1, bus.fpu_operand_2}),
          128'({1'b0, 1'b0, 1'b1, OP_ADD, 32'd0, 32'd0}));
    bus.in_valid = 1'b0;
    @(negedge clk);
    check({name, " idle"}, 128'({bus.in_ready, bus.busy, xfers}),
          128'({1'b1, 1'b0, x0 + 1}));
  endtask

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
    int          delay;
    int          stall;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [1:0]  r_op;
    logic [31:0] r_a, r_b, r_d;
    logic [4:0]  r_rd;
    logic        r_e, any_wb, prev_wb;
    int          r_delay, r_stall, r_lat, r_sel, x0;
    int          acc_q[$];
    logic [36:0] exp_q[$];
    logic [36:0] exp_wb;

    vecs[0] = '{"add_basic", OP_ADD, 32'h0000_0C00, 32'h0000_0400, 5'd5, 0, 0,
                32'h0000_1000, 1'b0, 2};
    vecs[1] = '{"sub_basic", OP_SUB, 32'h0000_1000, 32'h0000_0400, 5'd7, 0, 0,
                32'h0000_0C00, 1'b0, 2};
    vecs[2] = '{"mul_d6", OP_MUL, 32'h0000_0800, 32'h0000_0600, 5'd3, 6, 0,
                32'h0000_0C00, 1'b0, 7};
    vecs[3] = '{"mul_bp10", OP_MUL, 32'h0000_0800, 32'h0000_0600, 5'd9, 2, 10,
                32'h0000_0C00, 1'b0, 3};
    vecs[4] = '{"sqrt_never", OP_SQRT, 32'h0000_1234, 32'h0, 5'd12, 0, 0,
                32'h0000_0000, 1'b1, 64};
    vecs[5] = '{"sqrt_rdy63", OP_SQRT, 32'h0000_1234, 32'h0, 5'd13, 63, 0,
                32'h5A5A_486E, 1'b0, 64};
    vecs[6] = '{"sqrt_rdy64", OP_SQRT, 32'h0000_1234, 32'h0, 5'd14, 64, 1,
                32'h0000_0000, 1'b1, 64};
    vecs[7] = '{"add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 5'd31, 0, 3,
                32'h0000_0000, 1'b0, 2};
    vecs[8] = '{"sub_wrap", OP_SUB, 32'h0000_0000, 32'h0000_0001, 5'd0, 0, 0,
                32'hFFFF_FFFF, 1'b0, 2};
    vecs[9] = '{"mul_d1", OP_MUL, 32'h0000_0400, 32'h0000_0400, 5'd21, 1, 0,
                32'h0000_0400, 1'b0, 2};

    bus.in_valid = 1'b0;
    bus.in_op    = OP_ADD;
    bus.in_rs1   = '0;
    bus.in_rs2   = '0;
    bus.in_rd    = '0;
    bus.wb_ready = 1'b1;

    @(negedge clk);
    check("reset_state",
          128'({bus.in_ready, bus.busy, bus.wb_valid, bus.wb_err, bus.wb_data, bus.wb_rd,
                bus.fpu_operation, bus.fpu_operand_1, bus.fpu_operand_2}),
          128'({1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 5'd0, OP_ADD, 32'd0, 32'd0}));
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      do_req(vecs[i].name, vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].delay,
             vecs[i].stall, vecs[i].exp_data, vecs[i].exp_err, vecs[i].exp_lat);
    end

    // Reset in the third EXEC cycle of a MUL.
    @(negedge clk);
    stub_delay   = 10;
    bus.in_op    = OP_MUL;
    bus.in_rs1   = 32'h0000_0800;
    bus.in_rs2   = 32'h0000_0600;
    bus.in_rd    = 5'd3;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_pre", 128'({bus.busy, bus.in_ready, bus.fpu_operation}),
          128'({1'b1, 1'b0, OP_MUL}));
    reset = 1'b1;
    #1;
    check("rst_mid_exec",
          128'({bus.in_ready, bus.busy, bus.wb_valid, bus.wb_err, bus.wb_data, bus.wb_rd,
                bus.fpu_operation, bus.fpu_operand_1, bus.fpu_operand_2}),
          128'({1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 5'd0, OP_ADD, 32'd0, 32'd0}));
    @(negedge clk);
    reset  = 1'b0;
    x0     = xfers;
    any_wb = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.wb_valid) any_wb = 1'b1;
    end
    check("rst_no_wb", 128'({any_wb, xfers}), 128'({1'b0, x0}));
    do_req("add_after_rst", OP_ADD, 32'h0000_0C00, 32'h0000_0400, 5'd5, 0, 0,
           32'h0000_1000, 1'b0, 2);

    // Back-to-back: in_valid held high, fresh operands every cycle.
    @(negedge clk);
    stub_delay   = 0;
    bus.wb_ready = 1'b1;
    bus.in_op    = OP_ADD;
    bus.in_valid = 1'b1;
    prev_wb      = 1'b0;
    x0           = xfers;
    for (int c = 0; c < 12; c++) begin
      bus.in_rs1 = $urandom;
      bus.in_rs2 = $urandom;
      bus.in_rd  = 5'($urandom_range(0, 31));
      if (bus.in_ready) begin
        acc_q.push_back(c);
        exp_q.push_back({bus.in_rd, bus.in_rs1 + bus.in_rs2});
      end
      if (bus.wb_valid) begin
        exp_wb = (exp_q.size() > 0) ? exp_q.pop_front() : 37'h1F_FFFF_FFFF;
        check("b2b_wb", 128'({bus.wb_rd, bus.wb_data, bus.wb_err}), 128'({exp_wb, 1'b0}));
      end
      if (prev_wb) begin
        check("b2b_gap", 128'({bus.in_ready, bus.fpu_operation, bus.fpu_operand_1,
                                bus.fpu_operand_2}),
              128'({1'b0, OP_ADD, 32'd0, 32'd0}));
      end
      prev_wb = bus.wb_valid;
      if (c == 11) bus.in_valid = 1'b0;
      @(negedge clk);
    end
    check("b2b_count", 128'({acc_q.size(), xfers}), 128'({32'd3, x0 + 3}));
    foreach (acc_q[i]) check("b2b_spacing", 128'(acc_q[i]), 128'(4 * i));

    // Random requests against the reference model.
    for (int i = 0; i < 40; i++) begin
      r_op  = 2'($urandom_range(0, 3));
      r_a   = $urandom;
      r_b   = $urandom;
      r_rd  = 5'($urandom_range(0, 31));
      r_sel = $urandom_range(0, 9);
      r_delay = (r_sel == 0) ? 0 : (r_sel == 1) ? int'(TO) : $urandom_range(1, 12);
      r_stall = $urandom_range(0, 3);
      ref_model(r_op, r_a, r_b, r_delay, r_d, r_e, r_lat);
      do_req("rand", r_op, r_a, r_b, r_rd, r_delay, r_stall, r_d, r_e, r_lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
